// File: rtl/cart_bus_seq.sv
// Cartridge slot bus sequencer: one bus cycle every N hclk.
// Strobes are placed at fixed phases of cnt within each cycle.
module cart_bus_seq #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int DIV_NORMAL = 16,
  parameter int DIV_DOUBLE = 8
) (
  input  logic          hclk,
  input  logic          gbreset_n,
  input  logic          speed,
  input  logic          halt,
  input  logic          align,
  input  logic          req,
  input  logic          req_wr,
  input  logic          req_cs_n,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic [AW-1:0] CART_A,
  output logic          CART_CLK,
  output logic          CART_CS,
  output logic          CART_RD,
  output logic          CART_WR,
  output logic [DW-1:0] CART_DOUT,
  input  logic [DW-1:0] CART_DIN,
  output logic          CART_DATA_OE
);

  localparam int DMAX =
    (DIV_NORMAL > DIV_DOUBLE) ? DIV_NORMAL : DIV_DOUBLE;
  localparam int CW = $clog2(DMAX);

  typedef enum logic [1:0] {
    RUN_IDLE,
    RUN_RD,
    RUN_WR,
    HOLD
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [CW-1:0] n_m1, n_m2, n_h, n_h1, n_q;
  logic          dbl, started;
  logic          wrap, go, to_hold;
  logic          cs_lat;
  logic [DW-1:0] wd_lat;

  assign n_m1 = dbl ? CW'(DIV_DOUBLE - 1)   : CW'(DIV_NORMAL - 1);
  assign n_m2 = dbl ? CW'(DIV_DOUBLE - 2)   : CW'(DIV_NORMAL - 2);
  assign n_h  = dbl ? CW'(DIV_DOUBLE / 2)   : CW'(DIV_NORMAL / 2);
  assign n_h1 = dbl ? CW'(DIV_DOUBLE/2 - 1) : CW'(DIV_NORMAL/2 - 1);
  assign n_q  = dbl ? CW'(DIV_DOUBLE / 4)   : CW'(DIV_NORMAL / 4);

  assign cnt_inc = cnt + CW'(1);
  // The first edge out of reset behaves as a cycle boundary.
  assign wrap    = !started || (cnt == n_m1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_inc;
    go       = 1'b0;
    to_hold  = 1'b0;
    if (align) begin
      go = 1'b1;
    end else if (state == HOLD || wrap) begin
      go      = !halt;
      to_hold = halt;
    end
    if (go) begin
      cnt_nx = '0;
      if (!req)
        state_nx = RUN_IDLE;
      else if (req_wr)
        state_nx = RUN_WR;
      else
        state_nx = RUN_RD;
    end else if (to_hold) begin
      cnt_nx   = '0;
      state_nx = HOLD;
    end
  end

  always_ff @(posedge hclk or negedge gbreset_n) begin
    if (!gbreset_n) begin
      state   <= RUN_IDLE;
      cnt     <= '0;
      started <= 1'b0;
      dbl     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      started <= 1'b1;
      if (go)
        dbl <= speed;
    end
  end

  always_ff @(posedge hclk or negedge gbreset_n) begin
    if (!gbreset_n) begin
      CART_A       <= '0;
      CART_CLK     <= 1'b0;
      CART_CS      <= 1'b1;
      CART_RD      <= 1'b1;
      CART_WR      <= 1'b1;
      CART_DOUT    <= '0;
      CART_DATA_OE <= 1'b0;
      rdata        <= '0;
      rvalid       <= 1'b0;
      ack          <= 1'b0;
      cs_lat       <= 1'b1;
      wd_lat       <= '0;
    end else begin
      ack    <= 1'b0;
      // An align on the last edge of a read aborts it.
      rvalid <= (state == RUN_RD) && (cnt == n_m1) && !align;
      if (go) begin
        CART_CLK     <= 1'b1;
        CART_RD      <= 1'b0;
        CART_CS      <= 1'b1;
        CART_WR      <= 1'b1;
        CART_DATA_OE <= 1'b0;
        if (req) begin
          CART_A <= req_addr;
          wd_lat <= req_wdata;
          cs_lat <= req_cs_n;
          ack    <= 1'b1;
        end
      end else if (to_hold) begin
        CART_CLK     <= 1'b0;
        CART_CS      <= 1'b1;
        CART_RD      <= 1'b0;
        CART_WR      <= 1'b1;
        CART_DATA_OE <= 1'b0;
      end else begin
        if (cnt_inc == n_q && state != RUN_IDLE) begin
          CART_CS <= cs_lat;
          if (state == RUN_WR)
            CART_RD <= 1'b1;
        end
        if (cnt_inc == n_h1 && state == RUN_WR) begin
          CART_DATA_OE <= 1'b1;
          CART_DOUT    <= wd_lat;
        end
        if (cnt_inc == n_h) begin
          CART_CLK <= 1'b0;
          if (state == RUN_WR)
            CART_WR <= 1'b0;
        end
        if (cnt_inc == n_m2) begin
          CART_WR      <= 1'b1;
          CART_DATA_OE <= 1'b0;
        end
        if (cnt_inc == n_m1 && state == RUN_RD)
          rdata <= CART_DIN;
      end
    end
  end

endmodule

// File: tb/tb_cart_bus_seq.sv
// Bench for cart_bus_seq: phase-based reference model,
// directed scenarios with literal expectations, random traffic.
module tb_cart_bus_seq;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          hclk = 1'b0;
  logic          gbreset_n = 1'b0;
  logic          speed = 1'b0;
  logic          halt = 1'b0;
  logic          align = 1'b0;
  logic          req = 1'b0;
  logic          req_wr = 1'b0;
  logic          req_cs_n = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] CART_DIN = '0;
  logic          ack, rvalid;
  logic [DW-1:0] rdata, CART_DOUT;
  logic [AW-1:0] CART_A;
  logic          CART_CLK, CART_CS, CART_RD, CART_WR, CART_DATA_OE;

  always #5 hclk = ~hclk;

  cart_bus_seq #(
    .AW(AW), .DW(DW), .DIV_NORMAL(16), .DIV_DOUBLE(8)
  ) dut (
    .hclk(hclk), .gbreset_n(gbreset_n), .speed(speed),
    .halt(halt), .align(align), .req(req), .req_wr(req_wr),
    .req_cs_n(req_cs_n), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .rvalid(rvalid), .CART_A(CART_A), .CART_CLK(CART_CLK),
    .CART_CS(CART_CS), .CART_RD(CART_RD), .CART_WR(CART_WR),
    .CART_DOUT(CART_DOUT), .CART_DIN(CART_DIN),
    .CART_DATA_OE(CART_DATA_OE)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // Reference model: where are we in the current bus cycle?
  typedef enum int {K_IDLE, K_RD, K_WR} kind_e;
  bit            m_started, m_hold;
  int            m_k, m_n;
  kind_e         m_kind;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_dout, m_rdata;
  logic          m_cs, m_ack, m_rvalid;

  always @(posedge hclk or negedge gbreset_n) begin
    if (!gbreset_n) begin
      m_started = 0; m_hold = 0; m_k = 0; m_n = 16;
      m_kind = K_IDLE; m_addr = '0; m_wd = '0;
      m_dout = '0; m_rdata = '0; m_cs = 1'b1;
      m_ack = 1'b0; m_rvalid = 1'b0;
    end else begin : step
      bit boundary;
      boundary = !m_started || m_hold || (m_k == m_n - 1);
      m_ack = 1'b0;
      m_rvalid = m_started && !m_hold && m_kind == K_RD &&
                 m_k == m_n - 1 && !align;
      m_started = 1;
      if (align || (boundary && !halt)) begin
        m_hold = 0; m_k = 0;
        m_n = speed ? 8 : 16;
        if (req) begin
          m_kind = req_wr ? K_WR : K_RD;
          m_addr = req_addr; m_wd = req_wdata;
          m_cs = req_cs_n; m_ack = 1'b1;
        end else begin
          m_kind = K_IDLE;
        end
      end else if (boundary) begin
        m_hold = 1; m_k = 0; m_kind = K_IDLE;
      end else begin
        m_k++;
      end
      if (!m_hold && m_kind == K_RD && m_k == m_n - 1)
        m_rdata = CART_DIN;
      if (!m_hold && m_kind == K_WR && m_k == m_n/2 - 1)
        m_dout = m_wd;
    end
  end

  // Expected pin levels as a function of the cycle phase.
  always @(negedge hclk) begin : cmp
    logic e_clk, e_cs, e_rd, e_wr, e_oe;
    int q, h;
    q = m_n / 4;
    h = m_n / 2;
    if (!m_started) begin
      e_clk = 0; e_cs = 1; e_rd = 1; e_wr = 1; e_oe = 0;
    end else if (m_hold) begin
      e_clk = 0; e_cs = 1; e_rd = 0; e_wr = 1; e_oe = 0;
    end else begin
      e_clk = m_k < h;
      e_cs  = (m_kind != K_IDLE && m_k >= q) ? m_cs : 1'b1;
      e_rd  = m_kind == K_WR && m_k >= q;
      e_wr  = !(m_kind == K_WR && m_k >= h && m_k < m_n - 2);
      e_oe  = m_kind == K_WR && m_k >= h - 1 && m_k < m_n - 2;
    end
    check("m_ack",    32'(ack),          32'(m_ack));
    check("m_rvalid", 32'(rvalid),       32'(m_rvalid));
    check("m_rdata",  32'(rdata),        32'(m_rdata));
    check("m_clk",    32'(CART_CLK),     32'(e_clk));
    check("m_cs",     32'(CART_CS),      32'(e_cs));
    check("m_rd",     32'(CART_RD),      32'(e_rd));
    check("m_wr",     32'(CART_WR),      32'(e_wr));
    check("m_oe",     32'(CART_DATA_OE), 32'(e_oe));
    check("m_addr",   32'(CART_A),       32'(m_addr));
    check("m_dout",   32'(CART_DOUT),    32'(m_dout));
  end

  task automatic wait_ack();
    bit got;
    got = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge hclk);
      if (ack) begin
        got = 1;
        break;
      end
    end
    check("ack_wait", 32'(got), 32'(1));
  endtask

  task automatic wait_rise(output int n);
    logic prev;
    bit got;
    prev = CART_CLK;
    n = 0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge hclk);
      n++;
      if (CART_CLK && !prev) begin
        got = 1;
        break;
      end
      prev = CART_CLK;
    end
    check("clk_rise_wait", 32'(got), 32'(1));
  endtask

  initial begin
    int d, n1, n2;
    logic [6:0] rd_e, wr_e, oe_e;

    repeat (3) @(negedge hclk);
    check("rst_clk", 32'(CART_CLK), 32'(0));
    check("rst_cs",  32'(CART_CS),  32'(1));
    check("rst_rd",  32'(CART_RD),  32'(1));
    check("rst_wr",  32'(CART_WR),  32'(1));
    check("rst_oe",  32'(CART_DATA_OE), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_a",   32'(CART_A), 32'(0));
    gbreset_n = 1'b1;

    for (int j = 0; j < 32; j++) begin
      @(negedge hclk);
      check("clk_pattern", 32'(CART_CLK), 32'((j % 16) < 8));
      check("idle_cs", 32'(CART_CS), 32'(1));
    end

    // Normal-speed read.
    req_addr = 16'h4000; req_wr = 1'b0; req_cs_n = 1'b0;
    CART_DIN = 8'hA5; req = 1'b1;
    wait_ack();
    check("rd_addr", 32'(CART_A), 32'h4000);
    req = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge hclk);
      if (j == 3)  check("rd_cs_hi", 32'(CART_CS), 32'(1));
      if (j == 4)  check("rd_cs_lo", 32'(CART_CS), 32'(0));
      if (j == 15) check("rd_rv_early", 32'(rvalid), 32'(0));
      if (j == 16) begin
        check("rd_rvalid", 32'(rvalid), 32'(1));
        check("rd_data", 32'(rdata), 32'hA5);
      end
    end

    // Double-speed write; bit j-1 of each vector is phase j.
    rd_e = 7'b1111110;
    wr_e = 7'b1100111;
    oe_e = 7'b0011100;
    speed = 1'b1; req_addr = 16'h2000; req_wdata = 8'h3C;
    req_wr = 1'b1; req_cs_n = 1'b0; req = 1'b1;
    wait_ack();
    req = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge hclk);
      check("wr_rd", 32'(CART_RD), 32'(rd_e[j-1]));
      check("wr_wr", 32'(CART_WR), 32'(wr_e[j-1]));
      check("wr_oe", 32'(CART_DATA_OE), 32'(oe_e[j-1]));
      if (j == 3) check("wr_dout", 32'(CART_DOUT), 32'h3C);
    end

    // Speed change mid-cycle.
    speed = 1'b0;
    wait_rise(d);
    repeat (5) @(negedge hclk);
    speed = 1'b1;
    wait_rise(n1);
    check("spd_rest16", 32'(n1), 32'(11));
    wait_rise(n2);
    check("spd_next8", 32'(n2), 32'(8));

    // Halt at cnt = 5 with a read pending.
    speed = 1'b0;
    wait_rise(d);
    check("spd_back8", 32'(d), 32'(8));
    repeat (5) @(negedge hclk);
    halt = 1'b1; req_addr = 16'h1234; req_wr = 1'b0;
    req_cs_n = 1'b0; CART_DIN = 8'h5A; req = 1'b1;
    for (int j = 6; j <= 30; j++) begin
      @(negedge hclk);
      check("hold_noack", 32'(ack), 32'(0));
      check("hold_cs", 32'(CART_CS), 32'(1));
      if (j >= 8) check("hold_clk", 32'(CART_CLK), 32'(0));
    end
    halt = 1'b0;
    @(negedge hclk);
    check("hold_exit_ack", 32'(ack), 32'(1));
    check("hold_exit_clk", 32'(CART_CLK), 32'(1));
    check("hold_exit_a", 32'(CART_A), 32'h1234);
    req = 1'b0;

    // Align during a normal-speed write, next request pending.
    req_addr = 16'h5555; req_wdata = 8'h77; req_wr = 1'b1;
    req_cs_n = 1'b1; req = 1'b1;
    wait_ack();
    req_addr = 16'h6666; req_wr = 1'b0;
    repeat (10) @(negedge hclk);
    check("al_wr_lo", 32'(CART_WR), 32'(0));
    check("al_oe_hi", 32'(CART_DATA_OE), 32'(1));
    align = 1'b1;
    @(negedge hclk);
    align = 1'b0;
    check("al_wr_rel", 32'(CART_WR), 32'(1));
    check("al_oe_rel", 32'(CART_DATA_OE), 32'(0));
    check("al_ack", 32'(ack), 32'(1));
    check("al_addr", 32'(CART_A), 32'h6666);
    check("al_clk", 32'(CART_CLK), 32'(1));
    req = 1'b0;

    // Random traffic, one phase per speed.
    for (int ph = 0; ph < 2; ph++) begin
      speed = (ph == 1);
      for (int c = 0; c < 1500; c++) begin
        @(negedge hclk);
        CART_DIN = 8'($urandom);
        if (req && ack) req = 1'b0;
        if (!req && $urandom_range(0, 3) == 0) begin
          req = 1'b1;
          req_wr = 1'($urandom);
          req_addr = 16'($urandom);
          req_wdata = 8'($urandom);
          req_cs_n = ($urandom_range(0, 4) == 0);
        end
        if (halt)
          halt = ($urandom_range(0, 9) != 0);
        else
          halt = ($urandom_range(0, 99) == 0);
        align = (c > 20) && ($urandom_range(0, 149) == 0);
      end
    end
    halt = 1'b0; align = 1'b0;
    if (req) wait_ack();
    req = 1'b0;
    repeat (40) @(negedge hclk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
